// File: rtl/rubik_pkg.sv
// Shared cube definitions: move codes, inverse-move helper and undo-stack FSM states.
// Reused by the move controller, the undo stack and scramblers.
package rubik_pkg;

  localparam int unsigned MOVE_W = 4;

  localparam logic [MOVE_W-1:0] MV_NONE    = 4'd0;
  localparam logic [MOVE_W-1:0] MV_TOPC    = 4'd1;
  localparam logic [MOVE_W-1:0] MV_TOPCC   = 4'd2;
  localparam logic [MOVE_W-1:0] MV_BOTC    = 4'd3;
  localparam logic [MOVE_W-1:0] MV_BOTCC   = 4'd4;
  localparam logic [MOVE_W-1:0] MV_LEFTC   = 4'd5;
  localparam logic [MOVE_W-1:0] MV_LEFTCC  = 4'd6;
  localparam logic [MOVE_W-1:0] MV_RIGHTC  = 4'd7;
  localparam logic [MOVE_W-1:0] MV_RIGHTCC = 4'd8;
  localparam logic [MOVE_W-1:0] MV_BACKC   = 4'd9;
  localparam logic [MOVE_W-1:0] MV_BACKCC  = 4'd10;
  localparam logic [MOVE_W-1:0] MV_FRONTC  = 4'd11;
  localparam logic [MOVE_W-1:0] MV_FRONTCC = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_LAST  = 2'd2
  } undo_state_t;

  // True for the twelve real face moves.
  function automatic logic is_valid_move(input logic [MOVE_W-1:0] code);
    is_valid_move = (code != MV_NONE) && (code <= MV_FRONTCC);
  endfunction

  // cw <-> ccw of the same face; anything that is not a real move maps to MV_NONE.
  function automatic logic [MOVE_W-1:0] inv_move(input logic [MOVE_W-1:0] code);
    logic [MOVE_W-1:0] res;
    if (!is_valid_move(code)) begin
      res = MV_NONE;
    end else if (code[0]) begin
      res = code + 4'd1;
    end else begin
      res = code - 4'd1;
    end
    inv_move = res;
  endfunction

endpackage

// File: rtl/move_history_ram.sv
// DEPTH x 4 move history: one synchronous write port, one asynchronous read port.
module move_history_ram
  import rubik_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [MOVE_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [MOVE_W-1:0] rd_data_o
);

  logic [MOVE_W-1:0] mem_q [DEPTH];

  // Contents need no reset: count gates every read that matters.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/move_undo_stack.sv
// Records applied face moves and replays their inverses to the move controller,
// cancelling adjacent inverse pairs and keeping the most recent DEPTH moves.
module move_undo_stack
  import rubik_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rec_valid,
  input  logic [MOVE_W-1:0] rec_move,
  input  logic              undo_req,
  input  logic              undo_all,
  output logic              move_valid,
  output logic [MOVE_W-1:0] move_out,
  input  logic              move_ready,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic              busy,
  output logic              rec_dropped
);

  localparam int unsigned AW = $clog2(DEPTH);

  undo_state_t       state_q;
  logic [AW-1:0]     top_q;
  logic [CW-1:0]     count_q;
  logic              move_valid_q;
  logic [MOVE_W-1:0] move_out_q;
  logic              all_mode_q;
  logic              rec_dropped_q;

  logic [AW-1:0]     rd_addr;
  logic [MOVE_W-1:0] rd_data;
  logic              rec_ok;
  logic              cancel;
  logic              wr_en;
  logic              undo_start;
  logic              pop;

  // While issuing, the entry below the one being popped is prefetched.
  always_comb begin
    rd_addr    = top_q - AW'(1);
    if (state_q == ST_ISSUE) begin
      rd_addr = top_q - AW'(2);
    end
    rec_ok     = rec_valid && is_valid_move(rec_move) && (state_q == ST_IDLE);
    cancel     = rec_ok && (count_q != '0) && (rec_move == inv_move(rd_data));
    wr_en      = rec_ok && !cancel;
    undo_start = (state_q == ST_IDLE) && !rec_valid && (undo_req || undo_all)
                 && (count_q != '0);
    pop        = (state_q != ST_IDLE) && move_valid_q && move_ready;
  end

  move_history_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_hist (
    .clock     (clock),
    .wr_en_i   (wr_en),
    .wr_addr_i (top_q),
    .wr_data_i (rec_move),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Pointer, count and undo FSM.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      top_q         <= '0;
      count_q       <= '0;
      move_valid_q  <= 1'b0;
      move_out_q    <= MV_NONE;
      all_mode_q    <= 1'b0;
      rec_dropped_q <= 1'b0;
    end else begin
      if (rec_valid && !rec_ok) begin
        rec_dropped_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (cancel) begin
            top_q   <= top_q - AW'(1);
            count_q <= count_q - CW'(1);
          end else if (wr_en) begin
            top_q <= top_q + AW'(1);
            if (count_q != CW'(DEPTH)) begin
              count_q <= count_q + CW'(1);
            end
          end else if (undo_start) begin
            move_out_q   <= inv_move(rd_data);
            move_valid_q <= 1'b1;
            all_mode_q   <= undo_all;
            state_q      <= (undo_all && (count_q > CW'(1))) ? ST_ISSUE : ST_LAST;
          end
        end
        ST_ISSUE: begin
          if (pop) begin
            top_q      <= top_q - AW'(1);
            count_q    <= count_q - CW'(1);
            move_out_q <= inv_move(rd_data);
            state_q    <= (all_mode_q && (count_q > CW'(2))) ? ST_ISSUE : ST_LAST;
          end
        end
        ST_LAST: begin
          if (pop) begin
            top_q        <= top_q - AW'(1);
            count_q      <= count_q - CW'(1);
            move_valid_q <= 1'b0;
            move_out_q   <= MV_NONE;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign move_valid  = move_valid_q;
  assign move_out    = move_out_q;
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign busy        = (state_q != ST_IDLE);
  assign rec_dropped = rec_dropped_q;

endmodule

// File: tb/tb_move_undo_stack.sv
// Directed bench for move_undo_stack (DEPTH=4): vector table plus stall/reset sequences.
module tb_move_undo_stack;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clock;
  logic          reset;
  logic          rec_valid;
  logic [3:0]    rec_move;
  logic          undo_req;
  logic          undo_all;
  logic          move_valid;
  logic [3:0]    move_out;
  logic          move_ready;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          busy;
  logic          rec_dropped;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       rv;
    logic [3:0] rm;
    logic       ur;
    logic       ua;
    logic       rdy;
    logic       mv;
    logic [3:0] mo;
    logic [2:0] cnt;
    logic       bsy;
    logic       drop;
  } vec_t;

  vec_t vecs[$];

  move_undo_stack #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .rec_valid   (rec_valid),
    .rec_move    (rec_move),
    .undo_req    (undo_req),
    .undo_all    (undo_all),
    .move_valid  (move_valid),
    .move_out    (move_out),
    .move_ready  (move_ready),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .busy        (busy),
    .rec_dropped (rec_dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rv, input logic [3:0] rm, input logic ur,
                              input logic ua, input logic rdy, input logic mv,
                              input logic [3:0] mo, input logic [2:0] cnt,
                              input logic bsy, input logic drop);
    vec_t t;
    t.rv = rv; t.rm = rm; t.ur = ur; t.ua = ua; t.rdy = rdy;
    t.mv = mv; t.mo = mo; t.cnt = cnt; t.bsy = bsy; t.drop = drop;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic mv, input logic [3:0] mo,
                           input logic [2:0] cnt, input logic bsy, input logic drop);
    chk({tag, ".move_valid"},  int'(move_valid),  int'(mv));
    chk({tag, ".move_out"},    int'(move_out),    int'(mo));
    chk({tag, ".count"},       int'(count),       int'(cnt));
    chk({tag, ".empty"},       int'(empty),       int'(cnt == 3'd0));
    chk({tag, ".full"},        int'(full),        int'(cnt == 3'd4));
    chk({tag, ".busy"},        int'(busy),        int'(bsy));
    chk({tag, ".rec_dropped"}, int'(rec_dropped), int'(drop));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic step(input logic rv, input logic [3:0] rm, input logic ur,
                      input logic ua, input logic rdy);
    rec_valid  = rv;
    rec_move   = rm;
    undo_req   = ur;
    undo_all   = ua;
    move_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    rec_valid = 1'b0; rec_move = 4'd0; undo_req = 1'b0; undo_all = 1'b0; move_ready = 1'b0;

    //           rv rm    ur ua rdy   mv mo     cnt  bsy drop
    // undo_all after 1,7,11 -> 12, 8, 2
    vecs.push_back(mk(1, 4'd1,  0, 0, 0,   0, 4'd0,  3'd1, 0, 0));
    vecs.push_back(mk(1, 4'd7,  0, 0, 0,   0, 4'd0,  3'd2, 0, 0));
    vecs.push_back(mk(1, 4'd11, 0, 0, 0,   0, 4'd0,  3'd3, 0, 0));
    vecs.push_back(mk(0, 4'd0,  0, 1, 1,   1, 4'd12, 3'd3, 1, 0));
    vecs.push_back(mk(0, 4'd0,  0, 0, 1,   1, 4'd8,  3'd2, 1, 0));
    vecs.push_back(mk(0, 4'd0,  0, 0, 1,   1, 4'd2,  3'd1, 1, 0));
    vecs.push_back(mk(0, 4'd0,  0, 0, 1,   0, 4'd0,  3'd0, 0, 0));
    // cancel pair 5,6; no cancel for 3,3
    vecs.push_back(mk(1, 4'd5,  0, 0, 0,   0, 4'd0,  3'd1, 0, 0));
    vecs.push_back(mk(1, 4'd6,  0, 0, 0,   0, 4'd0,  3'd0, 0, 0));
    vecs.push_back(mk(1, 4'd3,  0, 0, 0,   0, 4'd0,  3'd1, 0, 0));
    vecs.push_back(mk(1, 4'd3,  0, 0, 0,   0, 4'd0,  3'd2, 0, 0));
    // single-step undo twice
    vecs.push_back(mk(0, 4'd0,  1, 0, 0,   1, 4'd4,  3'd2, 1, 0));
    vecs.push_back(mk(0, 4'd0,  0, 0, 1,   0, 4'd0,  3'd1, 0, 0));
    vecs.push_back(mk(0, 4'd0,  1, 0, 1,   1, 4'd4,  3'd1, 1, 0));
    vecs.push_back(mk(0, 4'd0,  0, 0, 1,   0, 4'd0,  3'd0, 0, 0));
    // undo on empty; record wins over simultaneous undo
    vecs.push_back(mk(0, 4'd0,  1, 0, 1,   0, 4'd0,  3'd0, 0, 0));
    vecs.push_back(mk(1, 4'd9,  1, 0, 1,   0, 4'd0,  3'd1, 0, 0));
    vecs.push_back(mk(0, 4'd0,  1, 0, 1,   1, 4'd10, 3'd1, 1, 0));
    vecs.push_back(mk(0, 4'd0,  0, 0, 1,   0, 4'd0,  3'd0, 0, 0));
    // wrap: 1,3,5,7,9 keeps 3..9; undo_all -> 10,8,6,4
    vecs.push_back(mk(1, 4'd1,  0, 0, 0,   0, 4'd0,  3'd1, 0, 0));
    vecs.push_back(mk(1, 4'd3,  0, 0, 0,   0, 4'd0,  3'd2, 0, 0));
    vecs.push_back(mk(1, 4'd5,  0, 0, 0,   0, 4'd0,  3'd3, 0, 0));
    vecs.push_back(mk(1, 4'd7,  0, 0, 0,   0, 4'd0,  3'd4, 0, 0));
    vecs.push_back(mk(1, 4'd9,  0, 0, 0,   0, 4'd0,  3'd4, 0, 0));
    vecs.push_back(mk(0, 4'd0,  0, 1, 1,   1, 4'd10, 3'd4, 1, 0));
    vecs.push_back(mk(0, 4'd0,  0, 0, 1,   1, 4'd8,  3'd3, 1, 0));
    vecs.push_back(mk(0, 4'd0,  0, 0, 1,   1, 4'd6,  3'd2, 1, 0));
    vecs.push_back(mk(0, 4'd0,  0, 0, 1,   1, 4'd4,  3'd1, 1, 0));
    vecs.push_back(mk(0, 4'd0,  0, 0, 1,   0, 4'd0,  3'd0, 0, 0));

    // Reset held for two edges.
    @(posedge clock); #1;
    @(posedge clock); #1;
    check_all("reset", 0, 4'd0, 3'd0, 0, 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].rv, vecs[i].rm, vecs[i].ur, vecs[i].ua, vecs[i].rdy);
      check_all($sformatf("vec%0d", i), vecs[i].mv, vecs[i].mo, vecs[i].cnt,
                vecs[i].bsy, vecs[i].drop);
    end

    // Stall: move_out held, record during stall dropped, then pop.
    step(1, 4'd9, 0, 0, 0);
    check_all("stall.rec", 0, 4'd0, 3'd1, 0, 0);
    step(0, 4'd0, 1, 0, 0);
    check_all("stall.start", 1, 4'd10, 3'd1, 1, 0);
    step(1, 4'd1, 0, 0, 0);
    check_all("stall.c1", 1, 4'd10, 3'd1, 1, 1);
    step(0, 4'd0, 0, 0, 0);
    check_all("stall.c2", 1, 4'd10, 3'd1, 1, 1);
    step(0, 4'd0, 0, 0, 0);
    check_all("stall.c3", 1, 4'd10, 3'd1, 1, 1);
    step(0, 4'd0, 0, 0, 1);
    check_all("stall.pop", 0, 4'd0, 3'd0, 0, 1);

    // Reset in the middle of undo_all after two moves issued.
    step(1, 4'd1, 0, 0, 0);
    step(1, 4'd3, 0, 0, 0);
    step(1, 4'd5, 0, 0, 0);
    step(1, 4'd7, 0, 0, 0);
    check_all("mid.fill", 0, 4'd0, 3'd4, 0, 1);
    step(0, 4'd0, 0, 1, 1);
    check_all("mid.first", 1, 4'd8, 3'd4, 1, 1);
    step(0, 4'd0, 0, 0, 1);
    check_all("mid.second", 1, 4'd6, 3'd3, 1, 1);
    reset = 1'b0;
    step(0, 4'd0, 0, 0, 1);
    check_all("mid.reset", 0, 4'd0, 3'd0, 0, 0);
    reset = 1'b1;
    step(0, 4'd0, 1, 0, 1);
    check_all("mid.undo_after", 0, 4'd0, 3'd0, 0, 0);

    // Invalid codes are dropped; the flag is sticky.
    step(1, 4'd13, 0, 0, 0);
    check_all("inv.13", 0, 4'd0, 3'd0, 0, 1);
    step(1, 4'd0, 0, 0, 0);
    check_all("inv.0", 0, 4'd0, 3'd0, 0, 1);
    step(1, 4'd12, 0, 0, 0);
    check_all("inv.after", 0, 4'd0, 3'd1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/move_undo_stack.md
# move_undo_stack

Records every face move applied to the cube register and plays them back as inverse moves on request, driving the controller's 4-bit move-code input in the opposite direction from normal play. Sits between the user move-entry logic and the move controller. Adjacent inverse pairs cancel on record, and a history buffer of fixed depth keeps the most recent moves. Supports single-step undo and undo-all.

## Interface
- DEPTH, 32, history entries; power of two, ≥ 4
- CW, $clog2(DEPTH+1), width of `count`
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; `reset==0` at a clock edge clears all state
- rec_valid  in  1  a move was applied by the user this cycle
- rec_move  in  4  applied move code
- undo_req  in  1  single-cycle pulse: undo one move
- undo_all  in  1  single-cycle pulse: undo until empty
- move_valid  out  1  `move_out` holds an inverse move for the controller
- move_out  out  4  inverse move code; 0 when `move_valid==0`
- move_ready  in  1  controller accepted `move_out` this cycle
- count  out  CW  entries held
- empty  out  1  `count==0`
- full  out  1  `count==DEPTH`
- busy  out  1  state ≠ IDLE
- rec_dropped  out  1  sticky: a record was ignored (invalid code or busy)

## Operation
- Move codes:
  - 1/2 top cw/ccw
  - 3/4 bottom
  - 5/6 left
  - 7/8 right
  - 9/10 back
  - 11/12 front
  - 0 = none
  - 13–15 invalid
- Inverse: odd code c → c+1; even code c → c−1.
- Storage: circular buffer `mem[DEPTH]`, top pointer `top` (index of next write), `count`.
- States: IDLE, ISSUE, LAST.
- IDLE, `rec_valid` with code 1..12:
  - If `count>0` and `rec_move == inverse(mem[top−1])`: cancel. `top−=1`, `count−=1`, nothing written.
  - Else write `mem[top]`, `top+=1` (mod DEPTH). `count` increments, saturating at DEPTH.
  - When full, the write overwrites the oldest entry: wrap-around, oldest move lost, `count` stays DEPTH.
- IDLE, `rec_valid` with code 0 or 13–15: ignored, `rec_dropped<=1`.
- Any state other than IDLE, `rec_valid`: ignored, `rec_dropped<=1`.
- IDLE, `undo_req` or `undo_all`, `count>0`, `rec_valid==0`:
  - Register `move_out=inverse(mem[top−1])` and `move_valid=1`.
  - Latch `all_mode=undo_all`.
  - Go to ISSUE if `all_mode` is set and `count>1`; otherwise go to LAST.
- `rec_valid` together with an undo pulse in IDLE: the record is processed and the undo pulse is discarded.
- Undo pulse while empty: no effect.
- ISSUE/LAST, `move_valid && move_ready` (handshake):
  - `top−=1`, `count−=1`.
  - In ISSUE: present the next inverse on the following cycle. Go to LAST when remaining `count==1` after the pop.
  - In LAST: clear `move_valid`, go to IDLE.
- While `move_valid==1 && move_ready==0`: `move_out` is held stable and the pointers do not change.
- Undo pulses outside IDLE: ignored.
- `rec_dropped` is cleared only by reset.

## Timing
- Reset values:
  - `move_valid=0`, `move_out=0`
  - `count=0`, `empty=1`, `full=0`, `busy=0`
  - `rec_dropped=0`, `top=0`, state IDLE
  - `mem` contents are don't-care
- Record: `count`/`full`/`empty` update on the edge sampling `rec_valid`. This is a 1-cycle latency.
- Undo: pulse sampled at edge N → `move_valid=1` after edge N. `move_out` is registered, with no combinational path from inputs.
- Handshake at edge M → the next `move_out` is valid after edge M in ISSUE, or `move_valid=0` after edge M in LAST. Back-to-back issue is one move per cycle when `move_ready` is held high.
- `reset==0` mid-undo: everything returns to reset values at that edge. The pending move is abandoned.

## Structure
- Shared package `rubik_pkg`:
  - move-code localparams (MV_NONE, MV_TOPC … MV_FRONTCC)
  - function `inv_move(code)`
  - state enum `undo_state_t`
- These are reused by the move controller and by future scramblers.
- One sub-module: `move_history_ram`, DEPTH×4 register array with one write port and one asynchronous read at `top−1`.
- Pointer, count and FSM logic stay in the top module.

## Test plan
- Reset with `reset=0` for 2 cycles → `count=0`, `empty=1`, `move_valid=0`, `move_out=0`, `rec_dropped=0`.
- Record 1, 7, 11; pulse `undo_all` with `move_ready=1` → `move_out` sequence 12, 8, 2 on consecutive cycles. Then `move_valid=0`, `count=0`, state IDLE.
- Record 5 then 6 → `count=0` (cancel). Record 3 then 3 → `count=2`, no cancel.
- DEPTH=4: record 1, 3, 5, 7, 9 → `count=4`, `full=1`. `undo_all` yields 10, 8, 6, 4; the oldest move (1) is lost.
- Record 9; `undo_req` with `move_ready=0` for 3 cycles → `move_out=10` held. Assert `rec_valid` with code 1 during the stall → ignored, `rec_dropped=1`. Then `move_ready=1` → pop, `count=0`.
- Mid-`undo_all` (2 of 4 issued), drive `reset=0` → next cycle `move_valid=0`, `count=0`. A subsequent `undo_req` has no effect.
